// File: rtl/pipe_flow_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: merges memory, mul/div, branch and load-use hazards.
// Optional PIPE_STALL_CNT_EN macro adds a wrapping counter of cycles with hold_pc asserted.
module pipe_flow_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld_use_hold,
   input  logic                  jump_flag,
   input  logic [ADDR_WIDTH-1:0] jump_addr,
   input  logic                  md_start,
   input  logic                  md_done,
   input  logic                  dmem_req,
   input  logic                  dmem_ack,
   output logic                  hold_pc,
   output logic                  hold_if_id,
   output logic                  hold_id_ex,
   output logic                  hold_ex_mem,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic                  flush_ex_mem,
   output logic                  flush_mem_wb,
   output logic                  pc_redirect,
   output logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  md_busy,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   typedef enum logic [1:0] {IDLE, MD_WAIT, MEM_WAIT} state_t;

   state_t state_q, state_d;
   logic   md_done_pend_q, md_done_pend_d;
   logic   mem_stall;
   logic   md_stall;

   always_comb begin
      mem_stall = dmem_req & ~dmem_ack;
      md_stall  = ((state_q == MD_WAIT) & ~md_done & ~md_done_pend_q) |
                  ((state_q == IDLE) & md_start & ~md_done);
   end

   // A mul/div completion arriving while EX is frozen by memory must not be lost,
   // so it is latched from the first frozen cycle onward.
   always_comb begin
      state_d        = state_q;
      md_done_pend_d = md_done_pend_q;
      if (mem_stall) begin
         state_d        = MEM_WAIT;
         md_done_pend_d = md_done_pend_q | md_done;
      end else begin
         case (state_q)
            MEM_WAIT: begin
               state_d        = (md_start & ~(md_done_pend_q | md_done)) ? MD_WAIT : IDLE;
               md_done_pend_d = 1'b0;
            end
            default: begin
               state_d = md_stall ? MD_WAIT : IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         md_done_pend_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         md_done_pend_q <= md_done_pend_d;
      end
   end

   // Outputs are gated by rst_n so the pipeline sees no controls while in reset.
   always_comb begin
      hold_pc       = 1'b0;
      hold_if_id    = 1'b0;
      hold_id_ex    = 1'b0;
      hold_ex_mem   = 1'b0;
      flush_if_id   = 1'b0;
      flush_id_ex   = 1'b0;
      flush_ex_mem  = 1'b0;
      flush_mem_wb  = 1'b0;
      pc_redirect   = 1'b0;
      redirect_addr = '0;
      md_busy       = 1'b0;
      if (rst_n) begin
         if (mem_stall) begin
            hold_pc      = 1'b1;
            hold_if_id   = 1'b1;
            hold_id_ex   = 1'b1;
            hold_ex_mem  = 1'b1;
            flush_mem_wb = 1'b1;
         end else if (md_stall) begin
            hold_pc      = 1'b1;
            hold_if_id   = 1'b1;
            hold_id_ex   = 1'b1;
            flush_ex_mem = 1'b1;
            md_busy      = 1'b1;
         end else if (jump_flag) begin
            pc_redirect   = 1'b1;
            redirect_addr = jump_addr;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
         end else if (ld_use_hold) begin
            hold_pc     = 1'b1;
            hold_if_id  = 1'b1;
            flush_id_ex = 1'b1;
         end
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hold_pc) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Scoreboard bench for pipe_flow_ctrl: driver queues hand-computed expectations, monitor compares each cycle.
module tb_pipe_flow_ctrl;

   localparam int AW = 32;
   localparam int CW = 4;

   // {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex,
   //  flush_ex_mem, flush_mem_wb, pc_redirect, md_busy}
   localparam logic [9:0] E_NONE = 10'b0000000000;
   localparam logic [9:0] E_MEM  = 10'b1111000100;
   localparam logic [9:0] E_MD   = 10'b1110001001;
   localparam logic [9:0] E_JMP  = 10'b0000110010;
   localparam logic [9:0] E_LDU  = 10'b1100010000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ld_use_hold = 1'b0;
   logic          jump_flag = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic          md_start = 1'b0;
   logic          md_done = 1'b0;
   logic          dmem_req = 1'b0;
   logic          dmem_ack = 1'b0;
   logic          hold_pc, hold_if_id, hold_id_ex, hold_ex_mem;
   logic          flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
   logic          pc_redirect, md_busy;
   logic [AW-1:0] redirect_addr;
   logic [CW-1:0] stall_cnt;

   typedef struct {
      logic [9:0]    outs;
      logic [AW-1:0] addr;
      logic [CW-1:0] cnt;
      int            id;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            passes = 0;
   int            vec_id = 0;
   logic [CW-1:0] cnt_tally = '0;

   pipe_flow_ctrl #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ld_use_hold(ld_use_hold), .jump_flag(jump_flag),
      .jump_addr(jump_addr), .md_start(md_start), .md_done(md_done),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack), .hold_pc(hold_pc),
      .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex), .hold_ex_mem(hold_ex_mem),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
      .flush_mem_wb(flush_mem_wb), .pc_redirect(pc_redirect), .redirect_addr(redirect_addr),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // One cycle of stimulus; the expected counter value is the tally of earlier expected hold_pc cycles.
   task automatic step(input logic rst, input logic ld, input logic jf, input logic [AW-1:0] ja,
                       input logic mds, input logic mdd, input logic req, input logic ack,
                       input logic [9:0] e, input logic [AW-1:0] ea);
      exp_t x;
      @(posedge clk);
      #1;
      rst_n = rst; ld_use_hold = ld; jump_flag = jf; jump_addr = ja;
      md_start = mds; md_done = mdd; dmem_req = req; dmem_ack = ack;
      if (!rst) cnt_tally = '0;
      x.outs = e;
      x.addr = ea;
`ifdef PIPE_STALL_CNT_EN
      x.cnt  = cnt_tally;
`else
      x.cnt  = '0;
`endif
      x.id   = vec_id;
      exp_q.push_back(x);
      vec_id++;
      if (rst && e[9]) cnt_tally = cnt_tally + CW'(1);
   endtask

   always @(negedge clk) begin
      exp_t x;
      logic [9:0] act;
      if (exp_q.size() > 0) begin
         x   = exp_q.pop_front();
         act = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex,
                flush_ex_mem, flush_mem_wb, pc_redirect, md_busy};
         checks++;
         if (act === x.outs) passes++;
         else $display("FAIL ctrl vec%0d: got %b want %b", x.id, act, x.outs);
         checks++;
         if (redirect_addr === x.addr) passes++;
         else $display("FAIL redirect_addr vec%0d: got %h want %h", x.id, redirect_addr, x.addr);
         checks++;
         if (stall_cnt === x.cnt) passes++;
         else $display("FAIL stall_cnt vec%0d: got %0d want %0d", x.id, stall_cnt, x.cnt);
         $display("vec%0d ctrl=%b addr=%h cnt=%0d", x.id, act, redirect_addr, stall_cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      // reset with a pending memory stall, then release
      step(0, 0, 0, 0, 0, 0, 1, 0, E_NONE, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, E_NONE, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, E_MEM,  0);
      step(1, 0, 0, 0, 0, 0, 1, 1, E_NONE, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      // load-use single bubble
      step(1, 1, 0, 0, 0, 0, 0, 0, E_LDU,  0);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      // jump wins over load-use; redirect_addr gated when no redirect
      step(1, 1, 1, 32'h100, 0, 0, 0, 0, E_JMP,  32'h100);
      step(1, 0, 0, 32'h100, 0, 0, 0, 0, E_NONE, 0);
      // mul/div: 4 stall cycles, release on md_done
      step(1, 0, 0, 0, 1, 0, 0, 0, E_MD,   0);
      step(1, 1, 0, 0, 1, 0, 0, 0, E_MD,   0);
      step(1, 0, 0, 0, 1, 0, 0, 0, E_MD,   0);
      step(1, 0, 0, 0, 1, 0, 0, 0, E_MD,   0);
      step(1, 0, 0, 0, 1, 1, 0, 0, E_NONE, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      // single-cycle mul/div: no stall
      step(1, 0, 0, 0, 1, 1, 0, 0, E_NONE, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      // memory over mul/div, md_done absorbed while frozen, exit straight to IDLE
      step(1, 0, 0, 0, 1, 0, 1, 0, E_MEM,  0);
      step(1, 0, 0, 0, 1, 1, 1, 0, E_MEM,  0);
      step(1, 0, 0, 0, 1, 0, 1, 0, E_MEM,  0);
      step(1, 0, 0, 0, 1, 0, 1, 1, E_NONE, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      // memory stall then mul/div still pending -> MD_WAIT keeps stalling
      step(1, 0, 0, 0, 1, 0, 1, 0, E_MEM,  0);
      step(1, 0, 0, 0, 1, 0, 1, 1, E_NONE, 0);
      step(1, 0, 0, 0, 1, 0, 0, 0, E_MD,   0);
      step(1, 0, 0, 0, 1, 1, 0, 0, E_NONE, 0);
      // jump held during freeze, taken on release
      step(1, 0, 1, 32'h2000_0040, 0, 0, 1, 0, E_MEM, 0);
      step(1, 0, 1, 32'h2000_0040, 0, 0, 1, 1, E_JMP, 32'h2000_0040);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      // reset mid mul/div stall aborts it
      step(1, 0, 0, 0, 1, 0, 0, 0, E_MD,   0);
      step(1, 0, 0, 0, 1, 0, 0, 0, E_MD,   0);
      step(0, 0, 0, 0, 1, 0, 0, 0, E_NONE, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      // 17 held cycles: 4-bit counter wraps to 1
      for (int i = 0; i < 17; i++) step(1, 1, 0, 0, 0, 0, 0, 0, E_LDU, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
